seg_display_ctrl: RTL and testbench

Parametrised sequential binary-to-seven-segment display controller. It converts a W-bit datapath result into DIGITS decimal digits using iterative double-dabble, one bit per clock, and drives a flat multi-digit segment bus. It adds signed display, leading-zero blanking, overflow indication and a start/busy/done handshake. It sits between the datapath output and the board's seven-segment displays as the general replacement for the fixed 8-bit, 3-digit decoder.

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg7_encode.sv | 24 ++
 rtl/seg_display_ctrl.sv | 135 +++++++++++++
 tb/tb_seg_display_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the sequential seven-segment display controller.
package seg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Active-high gfedcba patterns
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-decimal nibbles render blank
    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// One digit: BCD nibble to segment pattern, with dash/blank overrides and output polarity.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dash,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] segments
);

    logic [6:0] lit;

    always_comb begin
        lit = SEG_BLANK;
        if (dash) begin
            lit = SEG_DASH;
        end else if (!blank) begin
            lit = seg_pattern(nibble);
        end
        segments = active_low ? ~lit : lit;
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Binary to multi-digit seven-segment controller: one double-dabble step per clock,
// with sign display, leading-zero blanking, overflow dashes and start/busy/done handshake.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned W              = 8,
    parameter int unsigned DIGITS         = 3,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [W-1:0]          value,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [7*DIGITS-1:0] SEG_OFF = {(7*DIGITS){SEG_ACTIVE_LOW != 0}};

    state_t        state;
    logic [W-1:0]  mag;
    logic [BW-1:0] bcd;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          neg;
    logic          blank_r;

    logic [BW-1:0]         adj_c;
    logic [BW-1:0]         bcd_nx_c;
    logic [W-1:0]          mag_nx_c;
    logic                  carry_nx_c;
    logic                  ovf_c;
    logic [DIGITS-1:0]     zero_above_c;
    logic [7*DIGITS-1:0]   seg_c;

    // One double-dabble step plus the display decision for the final step
    always_comb begin
        logic all_zero;
        adj_c = bcd;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj_c[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        bcd_nx_c   = {adj_c[BW-2:0], mag[W-1]};
        mag_nx_c   = {mag[W-2:0], 1'b0};
        carry_nx_c = carry | adj_c[BW-1];
        ovf_c      = carry_nx_c | (neg & (bcd_nx_c[BW-1 -: 4] != 4'd0));

        all_zero     = 1'b1;
        zero_above_c = '0;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            all_zero        = all_zero & (bcd_nx_c[4*d +: 4] == 4'd0);
            zero_above_c[d] = all_zero;
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        localparam bit IS_TOP = (g == int'(DIGITS) - 1);
        localparam bit IS_LSD = (g == 0);
        logic dash;
        logic blank;

        // Digit 0 is never blanked; the sign digit shows dash regardless of blanking
        assign dash  = ovf_c | (neg & IS_TOP);
        assign blank = blank_r & !IS_LSD & zero_above_c[g];

        seg7_encode u_enc (
            .nibble     (bcd_nx_c[4*g +: 4]),
            .dash       (dash),
            .blank      (blank),
            .active_low (SEG_ACTIVE_LOW != 0),
            .segments   (seg_c[7*g +: 7])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            mag      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            neg      <= 1'b0;
            blank_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg      <= SEG_OFF;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Two's-complement negate; the most negative value maps to 2^(W-1)
                        if (signed_mode && value[W-1]) begin
                            mag <= (~value) + W'(1);
                            neg <= 1'b1;
                        end else begin
                            mag <= value;
                            neg <= 1'b0;
                        end
                        blank_r <= blank_lz;
                        bcd     <= '0;
                        carry   <= 1'b0;
                        cnt     <= CW'(W);
                        busy    <= 1'b1;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd   <= bcd_nx_c;
                    mag   <= mag_nx_c;
                    carry <= carry_nx_c;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf_c;
                        seg      <= seg_c;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: 8-bit/3-digit active-low instance plus
// 16-bit/4-digit instances in both polarities driven from shared inputs.
module tb_seg_display_ctrl;

    localparam int D = 10;  // dash
    localparam int B = 11;  // blank

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        start8, sm8, bl8;
    logic [7:0]  value8;
    logic        busy8, done8, ovf8;
    logic [20:0] seg8;

    logic        start16, sm16, bl16;
    logic [15:0] value16;
    logic        busy16, done16, ovf16, busy16n, done16n, ovf16n;
    logic [27:0] seg16, seg16n;

    int checks = 0;
    int fails  = 0;

    seg_display_ctrl #(.W(8), .DIGITS(3), .SEG_ACTIVE_LOW(1)) dut (
        .clock(clock), .reset_n(reset_n), .start(start8), .value(value8),
        .signed_mode(sm8), .blank_lz(bl8), .busy(busy8), .done(done8),
        .overflow(ovf8), .seg(seg8));

    seg_display_ctrl #(.W(16), .DIGITS(4), .SEG_ACTIVE_LOW(1)) dut16 (
        .clock(clock), .reset_n(reset_n), .start(start16), .value(value16),
        .signed_mode(sm16), .blank_lz(bl16), .busy(busy16), .done(done16),
        .overflow(ovf16), .seg(seg16));

    seg_display_ctrl #(.W(16), .DIGITS(4), .SEG_ACTIVE_LOW(0)) dut16n (
        .clock(clock), .reset_n(reset_n), .start(start16), .value(value16),
        .signed_mode(sm16), .blank_lz(bl16), .busy(busy16n), .done(done16n),
        .overflow(ovf16n), .seg(seg16n));

    function automatic logic [6:0] pat(input int c);
        case (c)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  D: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [20:0] exp3(input int d2, input int d1, input int d0);
        return ~{pat(d2), pat(d1), pat(d0)};
    endfunction

    function automatic logic [27:0] exp4h(input int d3, input int d2, input int d1, input int d0);
        return {pat(d3), pat(d2), pat(d1), pat(d0)};
    endfunction

    // Starts an 8-bit conversion at a negedge; returns done cycle (0 on timeout) and busy cycles
    task automatic conv8(input logic [7:0] v, input logic sm, input logic bl,
                         output int lat, output int bcnt);
        value8 = v; sm8 = sm; bl8 = bl; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        for (int n = 1; n <= 30; n++) begin
            if (busy8) bcnt++;
            if (done8) begin lat = n; break; end
            @(negedge clock);
        end
    endtask

    task automatic conv16(input logic [15:0] v, input logic sm, input logic bl,
                          output int lat, output int bcnt);
        value16 = v; sm16 = sm; bl16 = bl; start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        lat = 0; bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy16) bcnt++;
            if (done16) begin lat = n; break; end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start8 = 0; value8 = '0; sm8 = 0; bl8 = 0;
        start16 = 0; value16 = '0; sm16 = 0; bl16 = 0;
        @(negedge clock);
        checks++;
        if ({busy8, done8, ovf8} !== 3'b000) begin
            fails++; $display("FAIL reset_flags8: got %b expected 000", {busy8, done8, ovf8});
        end
        checks++;
        if (seg8 !== 21'h1FFFFF) begin
            fails++; $display("FAIL reset_seg8: got %h expected 1fffff", seg8);
        end
        checks++;
        if (seg16 !== 28'hFFFFFFF || seg16n !== 28'h0) begin
            fails++; $display("FAIL reset_seg16: got %h/%h expected fffffff/0000000", seg16, seg16n);
        end
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic [7:0] v;
        logic       sm;
        logic       bl;
        logic [3:0] d2, d1, d0;
        logic       ovf;
    } vec8_t;

    task automatic test_patterns8();
        vec8_t tbl [10];
        int lat, bcnt;
        logic [20:0] prev;
        tbl = '{
            '{8'd237, 1'b0, 1'b0, 4'd2, 4'd3, 4'd7, 1'b0},
            '{8'd5,   1'b0, 1'b1, 4'(B),4'(B),4'd5, 1'b0},
            '{8'd5,   1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 1'b0},
            '{8'd0,   1'b0, 1'b1, 4'(B),4'(B),4'd0, 1'b0},
            '{8'd255, 1'b0, 1'b1, 4'd2, 4'd5, 4'd5, 1'b0},
            '{8'hF6,  1'b1, 1'b0, 4'(D),4'd1, 4'd0, 1'b0},
            '{8'h80,  1'b1, 1'b0, 4'(D),4'(D),4'(D),1'b1},
            '{8'h63,  1'b1, 1'b0, 4'd0, 4'd9, 4'd9, 1'b0},
            '{8'hFB,  1'b1, 1'b1, 4'(D),4'(B),4'd5, 1'b0},
            '{8'hF6,  1'b0, 1'b1, 4'd2, 4'd4, 4'd6, 1'b0}
        };
        for (int i = 0; i < 10; i++) begin
            conv8(tbl[i].v, tbl[i].sm, tbl[i].bl, lat, bcnt);
            checks++;
            if (lat !== 9 || bcnt !== 8) begin
                fails++; $display("FAIL timing8[%0d]: got done@%0d busy=%0d expected done@9 busy=8", i, lat, bcnt);
            end
            checks++;
            if (seg8 !== exp3(int'(tbl[i].d2), int'(tbl[i].d1), int'(tbl[i].d0)) || ovf8 !== tbl[i].ovf) begin
                fails++; $display("FAIL result8[%0d] v=%h: got seg=%h ovf=%b expected seg=%h ovf=%b", i, tbl[i].v,
                    seg8, ovf8, exp3(int'(tbl[i].d2), int'(tbl[i].d1), int'(tbl[i].d0)), tbl[i].ovf);
            end
            prev = seg8;
            @(negedge clock);
            checks++;
            if (done8 !== 1'b0 || seg8 !== prev) begin
                fails++; $display("FAIL done_pulse8[%0d]: got done=%b seg=%h expected done=0 seg=%h", i, done8, seg8, prev);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        conv8(8'd123, 1'b0, 1'b0, lat, bcnt);
        conv8(8'd45, 1'b0, 1'b0, lat, bcnt);   // start issued in the done cycle
        checks++;
        if (lat !== 9 || seg8 !== exp3(0, 4, 5)) begin
            fails++; $display("FAIL back_to_back: got done@%0d seg=%h expected done@9 seg=%h", lat, seg8, exp3(0, 4, 5));
        end
    endtask

    task automatic test_start_held();
        int cnt = 0, first = 0, last = 0;
        value8 = 8'd200; sm8 = 0; bl8 = 0; start8 = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clock);
            if (n == 27) start8 = 1'b0;
            if (done8) begin
                cnt++;
                if (first == 0) first = n;
                last = n;
            end
        end
        checks++;
        if (cnt !== 3 || first !== 9 || last !== 27) begin
            fails++; $display("FAIL start_held: got %0d dones first@%0d last@%0d expected 3 first@9 last@27", cnt, first, last);
        end
        checks++;
        if (seg8 !== exp3(2, 0, 0)) begin
            fails++; $display("FAIL start_held_seg: got %h expected %h", seg8, exp3(2, 0, 0));
        end
        @(negedge clock);
    endtask

    task automatic test_start_ignored();
        int lat = 0;
        int stray = 0;
        int unstable = 0;
        logic [20:0] prev;
        prev = seg8;
        value8 = 8'd99; sm8 = 0; bl8 = 0; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin value8 = 8'hF1; sm8 = 1'b1; bl8 = 1'b1; end
            if (n == 4) start8 = 1'b1;
            if (n == 5) start8 = 1'b0;
            if (done8) begin lat = n; break; end
            if (seg8 !== prev || ovf8 !== 1'b0) unstable++;
            @(negedge clock);
        end
        checks++;
        if (unstable !== 0) begin
            fails++; $display("FAIL hold_during_conv: got %0d changed cycles expected 0", unstable);
        end
        checks++;
        if (lat !== 9 || seg8 !== exp3(0, 9, 9)) begin
            fails++; $display("FAIL start_ignored: got done@%0d seg=%h expected done@9 seg=%h", lat, seg8, exp3(0, 9, 9));
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (done8 || busy8) stray++;
        end
        checks++;
        if (stray !== 0) begin
            fails++; $display("FAIL stray_conv: got %0d busy/done cycles expected 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        conv8(8'h80, 1'b1, 1'b0, lat, bcnt);      // leaves overflow set
        value8 = 8'd237; sm8 = 0; bl8 = 0; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        repeat (3) @(negedge clock);              // cycle 4
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, ovf8} !== 3'b000 || seg8 !== 21'h1FFFFF) begin
            fails++; $display("FAIL reset_mid: got busy=%b done=%b ovf=%b seg=%h expected 0 0 0 1fffff",
                busy8, done8, ovf8, seg8);
        end
        @(negedge clock);
        reset_n = 1'b1;
        conv8(8'd237, 1'b0, 1'b0, lat, bcnt);     // any leftover done would show as early latency
        checks++;
        if (lat !== 9 || seg8 !== exp3(2, 3, 7) || ovf8 !== 1'b0) begin
            fails++; $display("FAIL after_reset: got done@%0d seg=%h ovf=%b expected done@9 seg=%h ovf=0",
                lat, seg8, ovf8, exp3(2, 3, 7));
        end
    endtask

    typedef struct packed {
        logic [15:0] v;
        logic        sm;
        logic        bl;
        logic [3:0]  d3, d2, d1, d0;
        logic        ovf;
    } vec16_t;

    task automatic test_wide();
        vec16_t tbl [5];
        int lat, bcnt;
        logic [27:0] e;
        tbl = '{
            '{16'd9999,  1'b0, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0},
            '{16'd54321, 1'b0, 1'b0, 4'(D),4'(D),4'(D),4'(D),1'b1},
            '{16'hFF85,  1'b1, 1'b1, 4'(D),4'd1, 4'd2, 4'd3, 1'b0},
            '{16'hFFF9,  1'b1, 1'b1, 4'(D),4'(B),4'(B),4'd7, 1'b0},
            '{16'd100,   1'b0, 1'b1, 4'(B),4'd1, 4'd0, 4'd0, 1'b0}
        };
        for (int i = 0; i < 5; i++) begin
            conv16(tbl[i].v, tbl[i].sm, tbl[i].bl, lat, bcnt);
            e = exp4h(int'(tbl[i].d3), int'(tbl[i].d2), int'(tbl[i].d1), int'(tbl[i].d0));
            checks++;
            if (lat !== 17 || bcnt !== 16 || done16n !== 1'b1) begin
                fails++; $display("FAIL timing16[%0d]: got done@%0d busy=%0d done_n=%b expected done@17 busy=16 done_n=1",
                    i, lat, bcnt, done16n);
            end
            checks++;
            if (seg16 !== ~e || ovf16 !== tbl[i].ovf) begin
                fails++; $display("FAIL result16[%0d] v=%h: got seg=%h ovf=%b expected seg=%h ovf=%b",
                    i, tbl[i].v, seg16, ovf16, ~e, tbl[i].ovf);
            end
            checks++;
            if (seg16n !== e || ovf16n !== tbl[i].ovf) begin
                fails++; $display("FAIL result16_high[%0d] v=%h: got seg=%h ovf=%b expected seg=%h ovf=%b",
                    i, tbl[i].v, seg16n, ovf16n, e, tbl[i].ovf);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_patterns8();
        test_back_to_back();
        test_start_held();
        test_start_ignored();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
